// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-high key matrix one column at a time,
// debounces a single key and reports its hex code with a one-cycle valid pulse.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_COUNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] code,
  output logic       valid,
  output logic       key_down
);

  localparam int            SW            = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST   = SW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    DEBOUNCE_LAST = 8'(DEBOUNCE_COUNT);

  typedef enum logic [1:0] {SCAN, PRESS, HELD} state_t;

  state_t        r_state,   w_stateNext;
  logic [SW-1:0] r_settle,  w_settleNext;
  logic [7:0]    r_cnt,     w_cntNext;
  logic [3:0]    r_col,     w_colNext;
  logic [1:0]    r_candRow, w_candRowNext;
  logic [1:0]    r_candCol, w_candColNext;
  logic [3:0]    r_code,    w_codeNext;
  logic          r_valid,   w_validNext;
  logic          r_keyDown, w_keyDownNext;

  logic          w_sample;
  logic [7:0]    w_cntInc;
  logic          w_cntDone;
  logic          w_hit;
  logic [1:0]    w_lowRow;
  logic [1:0]    w_colIdx;
  logic [3:0]    w_colRot;
  logic          w_accept;

  assign w_sample  = (r_settle == SETTLE_LAST);
  assign w_cntInc  = r_cnt + 8'd1;
  assign w_cntDone = (w_cntInc == DEBOUNCE_LAST);
  assign w_hit     = row[r_candRow];
  assign w_colIdx  = {r_col[3] | r_col[2], r_col[3] | r_col[1]};
  assign w_colRot  = {r_col[2:0], r_col[3]};
  // Lowest pressed row wins when several rows answer the same column.
  assign w_lowRow  = row[0] ? 2'd0 : row[1] ? 2'd1 : row[2] ? 2'd2 : 2'd3;

  assign col      = r_col;
  assign code     = r_code;
  assign valid    = r_valid;
  assign key_down = r_keyDown;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= SCAN;
      r_settle  <= '0;
      r_cnt     <= 8'd0;
      r_col     <= 4'b0001;
      r_candRow <= 2'd0;
      r_candCol <= 2'd0;
      r_code    <= 4'd0;
      r_valid   <= 1'b0;
      r_keyDown <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_settle  <= w_settleNext;
      r_cnt     <= w_cntNext;
      r_col     <= w_colNext;
      r_candRow <= w_candRowNext;
      r_candCol <= w_candColNext;
      r_code    <= w_codeNext;
      r_valid   <= w_validNext;
      r_keyDown <= w_keyDownNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_settleNext  = w_sample ? '0 : r_settle + 1'b1;
    w_cntNext     = r_cnt;
    w_colNext     = r_col;
    w_candRowNext = r_candRow;
    w_candColNext = r_candCol;
    w_codeNext    = r_code;
    w_validNext   = 1'b0;
    w_keyDownNext = r_keyDown;
    w_accept      = 1'b0;

    if (w_sample) begin
      unique case (r_state)
        SCAN: begin
          if (row == 4'd0) begin
            w_colNext = w_colRot;
          end else begin
            w_candRowNext = w_lowRow;
            w_candColNext = w_colIdx;
            w_cntNext     = 8'd1;
            w_stateNext   = PRESS;
            w_accept      = (DEBOUNCE_COUNT == 1);
          end
        end
        PRESS: begin
          if (w_hit) begin
            w_cntNext = w_cntInc;
            w_accept  = w_cntDone;
          end else begin
            w_cntNext   = 8'd0;
            w_stateNext = SCAN;
            w_colNext   = w_colRot;
          end
        end
        HELD: begin
          if (w_hit) begin
            w_cntNext = 8'd0;
          end else if (w_cntDone) begin
            w_cntNext     = 8'd0;
            w_keyDownNext = 1'b0;
            w_colNext     = 4'b0001;
            w_stateNext   = SCAN;
          end else begin
            w_cntNext = w_cntInc;
          end
        end
        default: w_stateNext = SCAN;
      endcase
    end

    // Acceptance publishes the code in the same cycle valid rises.
    if (w_accept) begin
      w_codeNext    = {w_candRowNext, w_candColNext};
      w_validNext   = 1'b1;
      w_keyDownNext = 1'b1;
      w_cntNext     = 8'd0;
      w_stateNext   = HELD;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a 4x4 key matrix model into keypad_scanner and checks
// every cycle against a behavioural model, plus fixed-timing directed scenarios.
module tb_keypad_scanner;

  localparam int S = 4;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] keys;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  code;
  logic        valid;
  logic        key_down;

  int nCompared   = 0;
  int nMismatched = 0;
  int validCount  = 0;
  bit checkEn     = 1'b0;

  int mCycle, mDwell, mColIdx, mMode, mCount, mCandRow, mCode;
  bit mValid, mKeyDown;

  always #5 clk = ~clk;

  // Key matrix: a row answers when any of its pressed keys sits in a driven column.
  always_comb begin
    row = 4'd0;
    for (int r = 0; r < 4; r++) row[r] = |(keys[4*r +: 4] & col);
  end

  keypad_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_COUNT(D)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .code(code), .valid(valid), .key_down(key_down)
  );

  // Behavioural model: mode 0 scanning, 1 confirming a press, 2 waiting for release.
  always @(posedge clk or posedge reset) begin
    bit accept;
    int low;
    if (reset) begin
      mCycle = 0; mDwell = 0; mColIdx = 0; mMode = 0; mCount = 0;
      mCandRow = 0; mCode = 0; mValid = 0; mKeyDown = 0;
    end else begin
      mCycle++;
      mValid = 0;
      accept = 0;
      if (mDwell == S - 1) begin
        mDwell = 0;
        if (mMode == 0) begin
          if (row == 4'd0) mColIdx = (mColIdx + 1) % 4;
          else begin
            low = 0;
            for (int r = 3; r >= 0; r--) if (row[r]) low = r;
            mCandRow = low; mCount = 1; mMode = 1;
            if (mCount >= D) accept = 1;
          end
        end else if (mMode == 1) begin
          if (row[mCandRow]) begin
            mCount++;
            if (mCount >= D) accept = 1;
          end else begin
            mCount = 0; mMode = 0; mColIdx = (mColIdx + 1) % 4;
          end
        end else begin
          if (!row[mCandRow]) begin
            mCount++;
            if (mCount >= D) begin
              mKeyDown = 0; mCount = 0; mMode = 0; mColIdx = 0;
            end
          end else mCount = 0;
        end
        if (accept) begin
          mCode = 4 * mCandRow + mColIdx;
          mValid = 1; mKeyDown = 1; mCount = 0; mMode = 2;
        end
      end else mDwell++;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t cycle=%0d)", name, act, exp, $time, mCycle);
    end
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) validCount++;
    if (checkEn) begin
      checkOutput("col", int'(col), 1 << mColIdx);
      checkOutput("code", int'(code), mCode);
      checkOutput("valid", int'(valid), int'(mValid));
      checkOutput("key_down", int'(key_down), int'(mKeyDown));
    end
  end

  // Called at a falling edge; holds keys k for the given number of cycles.
  task automatic applyStimulus(input logic [15:0] k, input int cycles);
    #2 keys = k;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic applyReset(input logic [15:0] k);
    @(negedge clk);
    #2 reset = 1'b1;
    keys = k;
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  // Waits for the falling edge at which n clock edges have passed since reset release.
  task automatic waitObs(input int n);
    int guard = 0;
    @(negedge clk);
    while (mCycle != n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) checkOutput("waitObs timeout", mCycle, n);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    logic [15:0] k;
    reset = 1'b1;
    keys  = 16'd0;
    repeat (2) @(negedge clk);
    applyReset(16'd0);
    checkEn = 1'b1;

    // Idle scan rotation and quiet outputs.
    base = validCount;
    waitObs(1);  checkOutput("idle col c1", int'(col), 1);
    waitObs(3);  checkOutput("idle col c3", int'(col), 1);
    waitObs(4);  checkOutput("idle col c4", int'(col), 2);
    waitObs(8);  checkOutput("idle col c8", int'(col), 4);
    waitObs(12); checkOutput("idle col c12", int'(col), 8);
    waitObs(16); checkOutput("idle col c16", int'(col), 1);
    checkOutput("idle code", int'(code), 0);
    checkOutput("idle key_down", int'(key_down), 0);
    checkOutput("idle valid count", validCount - base, 0);

    // Key 9 accepted 29 cycles after its column-1 sample, then released.
    applyReset(16'h0200);
    base = validCount;
    waitObs(35); checkOutput("key9 valid early", int'(valid), 0);
    waitObs(36);
    checkOutput("key9 valid", int'(valid), 1);
    checkOutput("key9 code", int'(code), 9);
    checkOutput("key9 key_down", int'(key_down), 1);
    checkOutput("key9 col held", int'(col), 2);
    applyStimulus(16'h0000, 0);
    waitObs(37); checkOutput("key9 valid one cycle", int'(valid), 0);
    waitObs(67); checkOutput("key9 key_down before release", int'(key_down), 1);
    waitObs(68);
    checkOutput("key9 key_down released", int'(key_down), 0);
    checkOutput("key9 col restart", int'(col), 1);
    checkOutput("key9 single valid", validCount - base, 1);

    // Key 5 bouncing: present three samples, absent one.
    applyReset(16'h0020);
    base = validCount;
    for (int j = 1; j < 200; j++) begin
      @(negedge clk);
      #2 keys = ((j % 16) < 12) ? 16'h0020 : 16'h0000;
    end
    @(negedge clk);
    checkOutput("bounce valid count", validCount - base, 0);
    checkOutput("bounce key_down", int'(key_down), 0);
    checkOutput("bounce col one-hot", $countones(col), 1);

    // Keys 6 and 14 share column 2: lower row wins.
    applyReset(16'h4040);
    waitObs(40);
    checkOutput("k6k14 valid", int'(valid), 1);
    checkOutput("k6k14 code", int'(code), 6);
    checkOutput("k6k14 col", int'(col), 4);

    // Keys 3 and 4: column 0 is scanned first.
    applyReset(16'h0018);
    waitObs(32);
    checkOutput("k3k4 valid", int'(valid), 1);
    checkOutput("k3k4 code", int'(code), 4);
    applyStimulus(16'h0000, 0);
    waitObs(64);
    checkOutput("k3k4 released", int'(key_down), 0);
    checkOutput("k3k4 col restart", int'(col), 1);

    // Key 12 detected, then reset lands mid-debounce.
    applyStimulus(16'h1000, 0);
    waitObs(77);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst code", int'(code), 0);
    checkOutput("rst key_down", int'(key_down), 0);
    checkOutput("rst valid", int'(valid), 0);
    checkOutput("rst col", int'(col), 1);
    base = validCount;
    @(negedge clk);
    #2 reset = 1'b0;
    waitObs(31);
    checkOutput("k12 no early valid", validCount - base, 0);
    waitObs(32);
    checkOutput("k12 valid", int'(valid), 1);
    checkOutput("k12 code", int'(code), 12);

    // Randomized key activity with occasional single-cycle dropouts.
    applyReset(16'h0000);
    @(negedge clk);
    for (int seg = 0; seg < 40; seg++) begin
      int r;
      int dur;
      r = $urandom_range(0, 9);
      if (r < 3) k = 16'h0000;
      else if (r < 8) k = 16'h0001 << $urandom_range(0, 15);
      else k = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      dur = $urandom_range(5, 250);
      for (int c = 0; c < dur; c++) begin
        #2 keys = ($urandom_range(0, 19) == 0) ? 16'h0000 : k;
        @(negedge clk);
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Active scanning end of the 4x4 hex keypad interface. It drives one-hot column strobes, samples the four row returns, debounces one key, and encodes it to a 4-bit hex code with a one-cycle valid strobe.
- Sits between the keypad matrix model, or the physical pads, and downstream logic such as display, command and register-entry blocks.
- Matrix convention: row[r] is high when key[4r+c] is pressed and col[c] is high. Code = 4*r + c.

Parameters:
- SETTLE_CYCLES, 4, clock cycles each column is driven before its rows are sampled (>=1).
- DEBOUNCE_COUNT, 8, consecutive identical samples required to accept a press or a release (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- row  input  4  row returns from the matrix, active-high.
- col  output  4  column drive, one-hot, active-high.
- code  output  4  hex code of the last accepted key; held until the next accept.
- valid  output  1  one-cycle pulse when a new key is accepted.
- key_down  output  1  level; high from accept until the release is debounced.

Behaviour:
- Reset, asynchronous and active-high:
  - Outputs: col=4'b0001, code=0, valid=0, key_down=0.
  - Internal: state=SCAN, settle counter=0, debounce counter=0.
  - Reset asserted mid-operation aborts immediately; no valid is produced.
- Sample point: every column dwell lasts SETTLE_CYCLES cycles. row is sampled on the last cycle of the dwell (settle counter == SETTLE_CYCLES-1). The settle counter then wraps to 0.
- SCAN:
  - If the sampled row == 0: col rotates left on the next cycle (0001->0010->0100->1000->0001). Full scan period = 4*SETTLE_CYCLES cycles.
  - If the sampled row != 0: latch cand_col = current column and cand_row = lowest set row bit (priority to row 0). Set debounce counter=1, go to PRESS. col is not advanced.
- PRESS:
  - col holds at cand_col.
  - At each sample point where row[cand_row]=1: counter++.
  - When the counter reaches DEBOUNCE_COUNT: on the next cycle set code={cand_row,cand_col}, valid=1 for exactly one cycle, key_down=1, counter=0, go to HELD.
  - If row[cand_row]=0 at any sample point: counter=0, return to SCAN. col advances to the next column; no output change.
  - DEBOUNCE_COUNT=1 means the detecting sample alone accepts the key.
- HELD:
  - col holds at cand_col. Other rows and columns are ignored; no rollover.
  - At each sample point where row[cand_row]=0: counter++. A sample with row[cand_row]=1 clears the counter.
  - When the counter reaches DEBOUNCE_COUNT: key_down=0 on the next cycle, counter=0, col=0001, go to SCAN.
- Latency: from the detecting sample cycle to valid high = (DEBOUNCE_COUNT-1)*SETTLE_CYCLES + 1 cycles. This is 29 cycles at the defaults.
- valid is never asserted on release, bounce or reset. code changes only in the cycle valid rises.
- Multiple keys:
  - Same column: lowest row wins.
  - Different columns: the first column sampled in scan order wins.
- Counter widths: settle counter is clog2(SETTLE_CYCLES) bits, minimum 1. Debounce counter is 8 bits. No wrap is possible because the counter resets on reaching its terminal value.
- All outputs are registered; there are no combinational paths from row to outputs.

Test Plan:
- Idle after reset (defaults) -> col=0001 for cycles 0-3, then 0010, 0100, 1000, and 0001 again at cycle 16. valid, key_down and code stay 0.
- Press key 9 (row2, col1) and hold -> detection when col=0010 is sampled. valid is high for one cycle 29 cycles later; code=4'h9; key_down=1; col is held at 0010.
- Release key 9 after acceptance -> key_down falls 29 cycles after the first low sample. No valid; col restarts at 0001 in the same cycle.
- Key 5 bounces (present 3 samples, absent 1, repeating) -> no valid, key_down stays 0, scanning continues.
- Keys 6 and 14 pressed together -> code=4'h6. Keys 3 and 4 pressed together from idle -> code=4'h4, because col0 is scanned first.
- Reset asserted 10 cycles after detecting key 12 -> all outputs return to reset values immediately; no valid pulse. After reset is released, the scan restarts and key 12 is reaccepted with full latency.
